// File: rtl/dcache_tag_ctrl.sv
// Data-cache tag RAM controller: arbitrates flush, update and lookup clients onto one RAM port.
// Define DCACHE_TAG_INIT_EN to sweep-invalidate every set automatically after reset.
module dcache_tag_ctrl #(
  parameter int NUM_SETS   = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_SETS),
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH,
  parameter int TAG_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lkup_req_i,
  input  logic [ADDR_WIDTH-1:0] lkup_addr_i,
  input  logic [TAG_WIDTH-1:0]  lkup_tag_i,
  output logic                  lkup_ready_o,
  output logic                  lkup_done_o,
  output logic                  lkup_hit_o,
  output logic                  lkup_dirty_o,
  output logic [TAG_WIDTH-1:0]  lkup_rtag_o,
  input  logic                  upd_req_i,
  input  logic [ADDR_WIDTH-1:0] upd_addr_i,
  input  logic [TAG_WIDTH-1:0]  upd_tag_i,
  input  logic                  upd_valid_i,
  input  logic                  upd_dirty_i,
  output logic                  upd_ready_o,
  input  logic                  flush_req_i,
  output logic                  flush_done_o,
  output logic                  ram_req_o,
  output logic [NUM_COL-1:0]    ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  output logic [1:0]            dbg_state_o
);

  // Handshake: a request transfers in any cycle where req and ready are both high;
  // ready is combinational from state and the higher-priority requests (flush > update > lookup).
  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_RESP, S_FLUSH} state_t;

`ifdef DCACHE_TAG_INIT_EN
  localparam state_t RST_STATE = S_FLUSH;
`else
  localparam state_t RST_STATE = S_IDLE;
`endif

  state_t                state;
  logic [ADDR_WIDTH-1:0] flush_cnt;
  logic [TAG_WIDTH-1:0]  cmp_tag;
  logic                  in_idle;
  logic                  upd_acc;
  logic                  lkup_acc;
  logic                  sweep;
  logic                  unused_rdata;

  // Upper RAM bits carry nothing; they are always written zero.
  assign unused_rdata = ^ram_rdata_i[DATA_WIDTH-1:TAG_WIDTH+2];
  assign dbg_state_o  = state;

  always_comb begin
    in_idle      = (state == S_IDLE);
    upd_ready_o  = in_idle && !flush_req_i;
    lkup_ready_o = in_idle && !flush_req_i && !upd_req_i;
    // Nothing is issued to the RAM while reset is held.
    upd_acc      = rst_n && upd_ready_o && upd_req_i;
    lkup_acc     = rst_n && lkup_ready_o && lkup_req_i;
    sweep        = rst_n && (state == S_FLUSH);
  end

  always_comb begin
    ram_req_o   = 1'b0;
    ram_wr_en_o = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (sweep) begin
      ram_req_o   = 1'b1;
      ram_wr_en_o = '1;
      ram_addr_o  = flush_cnt;
    end else if (upd_acc) begin
      ram_req_o   = 1'b1;
      ram_wr_en_o = '1;
      ram_addr_o  = upd_addr_i;
      ram_wdata_o[TAG_WIDTH+1:0] = {upd_dirty_i, upd_valid_i, upd_tag_i};
    end else if (lkup_acc) begin
      ram_req_o  = 1'b1;
      ram_addr_o = lkup_addr_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RST_STATE;
      flush_cnt    <= '0;
      cmp_tag      <= '0;
      lkup_done_o  <= 1'b0;
      lkup_hit_o   <= 1'b0;
      lkup_dirty_o <= 1'b0;
      lkup_rtag_o  <= '0;
      flush_done_o <= 1'b0;
    end else begin
      lkup_done_o  <= 1'b0;
      flush_done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (flush_req_i) begin
            state     <= S_FLUSH;
            flush_cnt <= '0;
          end else if (lkup_acc) begin
            cmp_tag <= lkup_tag_i;
            state   <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          // Read data is valid now; result outputs hold until the next lookup completes.
          lkup_hit_o   <= ram_rdata_i[TAG_WIDTH] && (ram_rdata_i[TAG_WIDTH-1:0] == cmp_tag);
          lkup_dirty_o <= ram_rdata_i[TAG_WIDTH+1];
          lkup_rtag_o  <= ram_rdata_i[TAG_WIDTH-1:0];
          lkup_done_o  <= 1'b1;
          state        <= S_RESP;
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        S_FLUSH: begin
          if (flush_cnt == ADDR_WIDTH'(NUM_SETS - 1)) begin
            flush_cnt    <= '0;
            flush_done_o <= 1'b1;
            state        <= S_IDLE;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// Bench for dcache_tag_ctrl: behavioural tag RAM, shadow tag model and lookup scoreboard.
// Also builds with DCACHE_TAG_INIT_EN defined to match the auto-invalidate variant.
module tb_dcache_tag_ctrl;
  localparam int NS = 32;
  localparam int AW = 5;
  localparam int NC = 4;
  localparam int DW = 32;
  localparam int TW = 24;
  localparam int EW = TW + 2;

`ifdef DCACHE_TAG_INIT_EN
  localparam logic RDY_RST = 1'b0;
`else
  localparam logic RDY_RST = 1'b1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lkup_req = 1'b0;
  logic [AW-1:0] lkup_addr = '0;
  logic [TW-1:0] lkup_tag = '0;
  logic          lkup_ready, lkup_done, lkup_hit, lkup_dirty;
  logic [TW-1:0] lkup_rtag;
  logic          upd_req = 1'b0;
  logic [AW-1:0] upd_addr = '0;
  logic [TW-1:0] upd_tag = '0;
  logic          upd_valid = 1'b0;
  logic          upd_dirty = 1'b0;
  logic          upd_ready;
  logic          flush_req = 1'b0;
  logic          flush_done;
  logic          ram_req;
  logic [NC-1:0] ram_wr_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [1:0]    dbg_state;

  dcache_tag_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .lkup_req_i(lkup_req), .lkup_addr_i(lkup_addr), .lkup_tag_i(lkup_tag),
    .lkup_ready_o(lkup_ready), .lkup_done_o(lkup_done), .lkup_hit_o(lkup_hit),
    .lkup_dirty_o(lkup_dirty), .lkup_rtag_o(lkup_rtag),
    .upd_req_i(upd_req), .upd_addr_i(upd_addr), .upd_tag_i(upd_tag),
    .upd_valid_i(upd_valid), .upd_dirty_i(upd_dirty), .upd_ready_o(upd_ready),
    .flush_req_i(flush_req), .flush_done_o(flush_done),
    .ram_req_o(ram_req), .ram_wr_en_o(ram_wr_en), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural tag RAM ----------------
  // Upper bits of read data are junk so the controller must ignore them.
  logic [DW-1:0] mem [NS];
  initial for (int i = 0; i < NS; i++) mem[i] = '0;

  always @(posedge clk) begin
    if (ram_req) begin
      if (ram_wr_en == '0)
        ram_rdata <= {6'($urandom_range(0, 63)), mem[ram_addr][EW-1:0]};
      for (int c = 0; c < NC; c++)
        if (ram_wr_en[c]) mem[ram_addr][c*8 +: 8] <= ram_wdata[c*8 +: 8];
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] shadow [NS];
  logic [EW-1:0] exp_q[$];
  logic acc_up, acc_lk, done_seen;

  initial for (int i = 0; i < NS; i++) shadow[i] = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called between edges: observes accepts, checks RAM traffic, pops results.
  task automatic monitor();
    logic [EW-1:0] e;
    logic [DW-1:0] wexp;
    acc_up = upd_req && upd_ready;
    acc_lk = lkup_req && lkup_ready;
    if (acc_up) begin
      wexp = '0;
      wexp[EW-1:0] = {upd_dirty, upd_valid, upd_tag};
      check("upd_ram", {ram_req, ram_wr_en, ram_addr, ram_wdata},
            {1'b1, 4'hf, upd_addr, wexp});
      shadow[upd_addr] = {upd_dirty, upd_valid, upd_tag};
    end else if (acc_lk) begin
      check("lk_ram", {ram_req, ram_wr_en, ram_addr}, {1'b1, 4'h0, lkup_addr});
      e = shadow[lkup_addr];
      exp_q.push_back({e[TW] && (e[TW-1:0] == lkup_tag), e[TW+1], e[TW-1:0]});
    end else begin
      check("idle_ram", {ram_req, ram_wr_en}, 5'h0);
    end
    if (lkup_done) begin
      done_seen = 1'b1;
      if (exp_q.size() == 0) check("lk_spurious", 1, 0);
      else check("lk_res", {lkup_hit, lkup_dirty, lkup_rtag}, exp_q.pop_front());
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_update(input int a, input logic [TW-1:0] t, input logic v, input logic d);
    int n;
    upd_addr = AW'(a); upd_tag = t; upd_valid = v; upd_dirty = d; upd_req = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!acc_up && n < 50);
    upd_req = 1'b0;
    if (!acc_up) check("upd_accept", 0, 1);
  endtask

  task automatic wait_done(input int exp_lat);
    int lat;
    lat = 0;
    while (!done_seen && lat < 10) begin tick(); lat++; end
    check("lk_latency", lat, exp_lat);
  endtask

  task automatic do_lookup(input int a, input logic [TW-1:0] t);
    int n;
    lkup_addr = AW'(a); lkup_tag = t; lkup_req = 1'b1;
    done_seen = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!acc_lk && n < 50);
    lkup_req = 1'b0;
    if (!acc_lk) check("lk_accept", 0, 1);
    wait_done(2);
  endtask

  // Positioned just after a rising edge at the first sweep cycle.
  task automatic check_sweep();
    for (int i = 0; i < NS; i++) begin
      @(negedge clk);
      check("sweep_wr", {ram_req, ram_wr_en, ram_addr, ram_wdata}, {1'b1, 4'hf, AW'(i), 32'h0});
      check("sweep_rdy", {upd_ready, lkup_ready, flush_done}, 3'b000);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("flush_done", flush_done, 1);
    monitor();
    @(posedge clk);
    #1;
    check("flush_done_1cyc", flush_done, 0);
  endtask

  task automatic do_flush();
    flush_req = 1'b1;
    @(negedge clk);
    check("flush_acc_rdy", {upd_ready, lkup_ready, ram_req}, 3'b000);
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    for (int i = 0; i < NS; i++) shadow[i] = '0;
    check_sweep();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_lk"}, {lkup_done, lkup_hit, lkup_dirty, lkup_rtag, flush_done}, 0);
    check({tag, "_ram"}, {ram_req, ram_wr_en, ram_addr, ram_wdata}, 0);
    check({tag, "_rdy"}, {upd_ready, lkup_ready}, {RDY_RST, RDY_RST});
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    logic [TW-1:0] t;
    #3;
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`ifdef DCACHE_TAG_INIT_EN
    check_sweep();
`endif
    tick();

    // basic hit / miss / invalidate on set 5
    do_update(5, 24'hABCDEF, 1'b1, 1'b1);
    do_lookup(5, 24'hABCDEF);
    do_lookup(5, 24'h123456);
    do_update(5, 24'hABCDEF, 1'b0, 1'b0);
    do_lookup(5, 24'hABCDEF);

    // back-to-back updates of every set, one per cycle
    upd_req = 1'b1;
    for (int i = 0; i < NS; i++) begin
      upd_addr = AW'(i); upd_tag = TW'($urandom); upd_valid = 1'b1;
      upd_dirty = 1'($urandom_range(0, 1));
      tick();
      check("b2b_upd", acc_up, 1);
    end
    upd_req = 1'b0;
    for (int i = 0; i < 4; i++) do_lookup(i * 9, shadow[i * 9][TW-1:0]);

    do_flush();
    for (int i = 0; i < NS; i++) do_lookup(i, 24'h0);

    // random mix of updates and hit/miss lookups
    for (int k = 0; k < 24; k++) begin
      n = $urandom_range(0, NS - 1);
      if ($urandom_range(0, 1) == 1)
        do_update(n, TW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        do_lookup(n, TW'($urandom_range(0, 7)));
    end

    // all three clients at once: flush first, then update, then lookup
    t = 24'h5A5A5A;
    upd_addr = 5'd9; upd_tag = t; upd_valid = 1'b1; upd_dirty = 1'b1; upd_req = 1'b1;
    lkup_addr = 5'd9; lkup_tag = t; lkup_req = 1'b1;
    done_seen = 1'b0;
    do_flush();
    check("pri_upd_first", {acc_up, acc_lk}, 2'b10);
    upd_req = 1'b0;
    tick();
    check("pri_lk_next", acc_lk, 1);
    lkup_req = 1'b0;
    wait_done(2);

    // reset in the middle of a flush sweep
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(ram_req && ram_addr == 5'd10) && n < 40);
    check("mid_flush_cnt10", {ram_req, ram_addr}, {1'b1, 5'd10});
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`ifdef DCACHE_TAG_INIT_EN
    check_sweep();
    for (int i = 0; i < NS; i++) shadow[i] = '0;
`else
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (flush_done || lkup_done || ram_req) n++;
      @(posedge clk);
      #1;
    end
    check("midrst_quiet", n, 0);
    @(negedge clk);
    check("midrst_rdy", {upd_ready, lkup_ready}, 2'b11);
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) shadow[i] = '0;
`endif
    do_update(3, 24'h00C0DE, 1'b1, 1'b0);
    do_lookup(3, 24'h00C0DE);

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
